// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_hs #(
    parameter int WIDTH = 16,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             clr_cnt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // With the skid buffer, in_ready is a pure decode of the state register,
    // so no combinational path exists from out_ready.
    generate
        if (SKID != 0) begin : g_skid_rdy
            assign in_ready = (state_q != ST_SKID);
        end else begin : g_comb_rdy
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_FULL;
                    main_d  = in_data;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    if (SKID != 0) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else begin
                        main_d = in_data;
                    end
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush squashes everything; payload regs simply keep their old contents.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three configurations (skid, no skid, skid with 3-bit
// counter) share one stimulus stream and are compared against a queue model.
module tb_pipe_stage_hs;

    logic        clk = 1'b0;
    logic        reset, flush, clr_cnt, in_valid, out_ready;
    logic [15:0] in_data;

    logic        ir  [3];
    logic        ov  [3];
    logic [15:0] od  [3];
    logic [1:0]  occ [3];
    logic [15:0] sc0, sc1;
    logic [2:0]  sc2;

    int          nvec = 0;
    int          nerr = 0;

    logic [15:0] mq [3][$];
    int          mcnt [3];
    int          mskid [3] = '{1, 0, 1};
    int          mmax  [3] = '{65535, 65535, 7};

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(16), .SKID(1), .CNT_W(16)) u_s1 (
        .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0]), .stall_cnt(sc0));

    pipe_stage_hs #(.WIDTH(16), .SKID(0), .CNT_W(16)) u_s0 (
        .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1]), .stall_cnt(sc1));

    pipe_stage_hs #(.WIDTH(16), .SKID(1), .CNT_W(3)) u_c3 (
        .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ[2]), .stall_cnt(sc2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] scnt(input int i);
        if (i == 0) return sc0;
        if (i == 1) return sc1;
        return {13'b0, sc2};
    endfunction

    function automatic logic mir(input int i);
        if (mskid[i] != 0) return (mq[i].size() < 2);
        return (mq[i].size() == 0) || out_ready;
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ov%0d", i),  32'(ov[i]),  32'(mq[i].size() != 0));
            chk($sformatf("occ%0d", i), 32'(occ[i]), 32'(mq[i].size()));
            chk($sformatf("ir%0d", i),  32'(ir[i]),  32'(mir(i)));
            chk($sformatf("sc%0d", i),  32'(scnt(i)), 32'(mcnt[i]));
            if (mq[i].size() != 0)
                chk($sformatf("od%0d", i), 32'(od[i]), 32'(mq[i][0]));
        end
    endtask

    // Called at a falling edge: drive, advance the model by one edge, check.
    task automatic step(input logic iv, input logic [15:0] d, input logic ordy,
                        input logic fl, input logic clr);
        logic r0, r2;
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl; clr_cnt = clr;
        #1;
        r0 = ir[0]; r2 = ir[2];
        out_ready = ~ordy;
        #1;
        chk("irc0", 32'(ir[0]), 32'(r0));
        chk("irc2", 32'(ir[2]), 32'(r2));
        out_ready = ordy;
        #1;
        for (int i = 0; i < 3; i++) begin
            logic rdy, v, inf, outf;
            rdy  = mir(i);
            v    = (mq[i].size() != 0);
            inf  = iv && rdy;
            outf = v && ordy;
            if (clr) mcnt[i] = 0;
            else if (v && !ordy && mcnt[i] < mmax[i]) mcnt[i]++;
            if (fl) mq[i].delete();
            else begin
                if (outf) void'(mq[i].pop_front());
                if (inf)  mq[i].push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0; in_data = '0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ov%0d", i),  32'(ov[i]),  32'd0);
            chk($sformatf("rst_ir%0d", i),  32'(ir[i]),  32'd1);
            chk($sformatf("rst_od%0d", i),  32'(od[i]),  32'd0);
            chk($sformatf("rst_occ%0d", i), 32'(occ[i]), 32'd0);
            chk($sformatf("rst_sc%0d", i),  32'(scnt(i)), 32'd0);
            mq[i].delete();
            mcnt[i] = 0;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        do_reset();

        // latency and full-rate streaming
        step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        chk("t1_ov", 32'(ov[0]), 32'd1);
        chk("t1_od", 32'(od[0]), 32'h1234);
        chk("t1_od_s0", 32'(od[1]), 32'h1234);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'(16'hA000 + k), 1'b1, 1'b0, 1'b0);
            chk("t1_ir_s1", 32'(ir[0]), 32'd1);
            chk("t1_ir_s0", 32'(ir[1]), 32'd1);
            chk("t1_stream", 32'(od[0]), 32'(16'hA000 + k));
        end
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // skid fill and drain
        step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0);
        chk("t2_occ", 32'(occ[0]), 32'd2);
        chk("t2_ir", 32'(ir[0]), 32'd0);
        chk("t2_od", 32'(od[0]), 32'h00AA);
        chk("t2_occ_s0", 32'(occ[1]), 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("t2_od_b", 32'(od[0]), 32'h00BB);
        chk("t2_occ1", 32'(occ[0]), 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("t2_occ0", 32'(occ[0]), 32'd0);

        // flush while full
        step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00CC, 1'b0, 1'b1, 1'b0);
        chk("t3_ov", 32'(ov[0]), 32'd0);
        chk("t3_occ", 32'(occ[0]), 32'd0);
        chk("t3_ir", 32'(ir[0]), 32'd1);
        step(1'b1, 16'h00DD, 1'b1, 1'b0, 1'b0);
        chk("t3_od", 32'(od[0]), 32'h00DD);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // stall counter: count, clear-wins, saturation
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("t4_cnt5", 32'(sc0), 32'd5);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t4_clr", 32'(sc0), 32'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("t4_sat", 32'(sc2), 32'd7);
        chk("t4_cnt10", 32'(sc0), 32'd10);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // asynchronous reset with two entries held
        step(1'b1, 16'h0A0A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0B0B, 1'b0, 1'b0, 1'b0);
        chk("t5_occ", 32'(occ[0]), 32'd2);
        do_reset();
        step(1'b1, 16'h0F0F, 1'b1, 1'b0, 1'b0);
        chk("t5_after", 32'(od[0]), 32'h0F0F);

        // random traffic against the queue model
        for (int n = 0; n < 10000; n++) begin
            logic iv, ordy, fl, clr;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (n % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            clr  = ($urandom_range(0, 127) == 0);
            step(iv, 16'($urandom), ordy, fl, clr);
            if (n == 5000) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
